// File: rtl/brc_iter.sv
// ---------------------------------------------------------------------------
// brc_iter -- iterative RISC-V branch comparator.
//
// Compares two XLEN-bit operands CHUNK bits per cycle, starting with the
// most significant chunk, and produces less/equal flags plus the branch
// decision selected by funct3. The top chunk carries the sign, so it is
// compared signed in signed mode; every lower chunk is compared unsigned.
// With EARLY_EXIT=1 the walk stops at the first differing chunk. With
// EARLY_EXIT=0 it always visits all NCH chunks, which gives a fixed latency.
//
// Ports:
//   i_clk        sole clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_valid      request valid (only observed in IDLE)
//   o_ready      high while the block is idle and can accept a request
//   i_rs1_data   operand A
//   i_rs2_data   operand B
//   i_br_un      unsigned compare request
//   i_funct3     RISC-V branch funct3
//   o_valid      result valid, held until i_ready
//   i_ready      consumer accepts the result
//   o_br_less    A < B
//   o_br_equal   A == B
//   o_br_taken   branch decision for the captured funct3
//   o_br_illegal captured funct3 was 010 or 011
// ---------------------------------------------------------------------------
module brc_iter #(
    parameter int XLEN       = 32,
    parameter int CHUNK      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic            i_br_un,
    input  logic [2:0]      i_funct3,
    output logic            o_valid,
    input  logic            i_ready,
    output logic            o_br_less,
    output logic            o_br_equal,
    output logic            o_br_taken,
    output logic            o_br_illegal
);

    localparam int NCH  = XLEN / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [IDXW-1:0] IDX_TOP  = IDXW'(NCH - 1);
    localparam logic [IDXW-1:0] IDX_ZERO = IDXW'(0);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Branch decision for a legal funct3; illegal encodings never branch.
    function automatic logic taken_f(input logic [2:0] f3,
                                     input logic       less,
                                     input logic       equal);
        logic t;
        case (f3)
            3'b000:         t = equal;
            3'b001:         t = ~equal;
            3'b100, 3'b110: t = less;
            3'b101, 3'b111: t = ~less;
            default:        t = 1'b0;
        endcase
        return t;
    endfunction

    // funct3 values 010 and 011 are not branch encodings.
    function automatic logic illegal_f(input logic [2:0] f3);
        return (f3 == 3'b010) || (f3 == 3'b011);
    endfunction

    state_t          state_r;
    logic [XLEN-1:0] rs1_r;
    logic [XLEN-1:0] rs2_r;
    logic [2:0]      funct3_r;
    logic            unsigned_r;
    logic [IDXW-1:0] idx_r;
    logic            diff_found_r;
    logic            diff_less_r;
    logic            valid_r;
    logic            less_r;
    logic            equal_r;
    logic            taken_r;
    logic            illegal_r;

    logic [CHUNK-1:0] chunk_a_s;
    logic [CHUNK-1:0] chunk_b_s;
    logic             top_signed_s;
    logic             chunk_less_s;
    logic             diff_s;
    logic             finish_s;
    logic             res_less_s;
    logic             res_equal_s;

    // Select the chunk under examination and compare it.
    always_comb begin
        chunk_a_s    = CHUNK'(rs1_r >> (int'(idx_r) * CHUNK));
        chunk_b_s    = CHUNK'(rs2_r >> (int'(idx_r) * CHUNK));
        top_signed_s = (idx_r == IDX_TOP) && !unsigned_r;
        diff_s       = (chunk_a_s != chunk_b_s);
        if (top_signed_s) begin
            chunk_less_s = ($signed(chunk_a_s) < $signed(chunk_b_s));
        end else begin
            chunk_less_s = (chunk_a_s < chunk_b_s);
        end
    end

    // Decide whether this CMP cycle ends the walk and what the result is.
    always_comb begin
        finish_s    = 1'b0;
        res_less_s  = 1'b0;
        res_equal_s = 1'b1;
        if (EARLY_EXIT != 0) begin
            if (diff_s) begin
                finish_s    = 1'b1;
                res_less_s  = chunk_less_s;
                res_equal_s = 1'b0;
            end else begin
                finish_s    = (idx_r == IDX_ZERO);
                res_less_s  = 1'b0;
                res_equal_s = 1'b1;
            end
        end else begin
            finish_s = (idx_r == IDX_ZERO);
            // The most significant difference wins, even if it was seen
            // several cycles ago.
            if (diff_found_r) begin
                res_less_s  = diff_less_r;
                res_equal_s = 1'b0;
            end else if (diff_s) begin
                res_less_s  = chunk_less_s;
                res_equal_s = 1'b0;
            end else begin
                res_less_s  = 1'b0;
                res_equal_s = 1'b1;
            end
        end
    end

    // Control FSM, operand capture and registered result outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r      <= ST_IDLE;
            rs1_r        <= {XLEN{1'b0}};
            rs2_r        <= {XLEN{1'b0}};
            funct3_r     <= 3'b000;
            unsigned_r   <= 1'b0;
            idx_r        <= IDX_ZERO;
            diff_found_r <= 1'b0;
            diff_less_r  <= 1'b0;
            valid_r      <= 1'b0;
            less_r       <= 1'b0;
            equal_r      <= 1'b0;
            taken_r      <= 1'b0;
            illegal_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_valid) begin
                        rs1_r        <= i_rs1_data;
                        rs2_r        <= i_rs2_data;
                        funct3_r     <= i_funct3;
                        // funct3[1] marks BLTU/BGEU, which are unsigned
                        // regardless of i_br_un.
                        unsigned_r   <= i_br_un | i_funct3[1];
                        idx_r        <= IDX_TOP;
                        diff_found_r <= 1'b0;
                        diff_less_r  <= 1'b0;
                        state_r      <= ST_CMP;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end
                ST_CMP: begin
                    if (diff_s && !diff_found_r) begin
                        diff_found_r <= 1'b1;
                        diff_less_r  <= chunk_less_s;
                    end
                    if (finish_s) begin
                        less_r    <= res_less_s;
                        equal_r   <= res_equal_s;
                        taken_r   <= taken_f(funct3_r, res_less_s, res_equal_s);
                        illegal_r <= illegal_f(funct3_r);
                        valid_r   <= 1'b1;
                        state_r   <= ST_DONE;
                    end else begin
                        idx_r     <= idx_r - IDX_ONE;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        valid_r <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ready      = (state_r == ST_IDLE);
    assign o_valid      = valid_r;
    assign o_br_less    = less_r;
    assign o_br_equal   = equal_r;
    assign o_br_taken   = taken_r;
    assign o_br_illegal = illegal_r;

endmodule

// File: tb/tb_brc_iter.sv
// ---------------------------------------------------------------------------
// tb_brc_iter -- directed scoreboard bench for brc_iter.
// Two instances share one stimulus stream: one with EARLY_EXIT=1 and one
// with EARLY_EXIT=0. Expected results and latencies are computed from a
// full-width reference compare and pushed to a queue per instance when a
// request is driven. They are popped and compared when o_valid appears.
// ---------------------------------------------------------------------------
module tb_brc_iter;

    typedef struct {
        logic less;
        logic equal;
        logic taken;
        logic illegal;
        int   lat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        br_un;
    logic [2:0]  funct3;
    logic        in_ready;

    logic ee_ready, ee_valid, ee_less, ee_equal, ee_taken, ee_illegal;
    logic fu_ready, fu_valid, fu_less, fu_equal, fu_taken, fu_illegal;

    int total = 0;
    int bad   = 0;

    exp_t q_ee[$];
    exp_t q_fu[$];

    brc_iter #(.XLEN(32), .CHUNK(8), .EARLY_EXIT(1)) dut_ee (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .o_ready(ee_ready),
        .i_rs1_data(rs1), .i_rs2_data(rs2), .i_br_un(br_un), .i_funct3(funct3),
        .o_valid(ee_valid), .i_ready(in_ready), .o_br_less(ee_less),
        .o_br_equal(ee_equal), .o_br_taken(ee_taken), .o_br_illegal(ee_illegal)
    );

    brc_iter #(.XLEN(32), .CHUNK(8), .EARLY_EXIT(0)) dut_fu (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .o_ready(fu_ready),
        .i_rs1_data(rs1), .i_rs2_data(rs2), .i_br_un(br_un), .i_funct3(funct3),
        .o_valid(fu_valid), .i_ready(in_ready), .o_br_less(fu_less),
        .o_br_equal(fu_equal), .o_br_taken(fu_taken), .o_br_illegal(fu_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference result: full-width compare plus latency in chunks examined.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic un, input logic [2:0] f3,
                                   input logic early);
        exp_t e;
        logic u;
        u = un | f3[1];
        e.less  = u ? (a < b) : ($signed(a) < $signed(b));
        e.equal = (a == b);
        case (f3)
            3'b000:         e.taken = e.equal;
            3'b001:         e.taken = !e.equal;
            3'b100, 3'b110: e.taken = e.less;
            3'b101, 3'b111: e.taken = !e.less;
            default:        e.taken = 1'b0;
        endcase
        e.illegal = (f3 == 3'b010) || (f3 == 3'b011);
        e.lat = 4;
        if (early) begin
            for (int c = 0; c < 4; c++) begin
                if (a[c*8 +: 8] != b[c*8 +: 8]) e.lat = 4 - c;
            end
        end
        return e;
    endfunction

    // Drive one request, check both instances, optionally stall, then handshake.
    task automatic do_req(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic un, input logic [2:0] f3, input int hold);
        exp_t e0;
        exp_t e1;
        int   lat;
        int   lat0;
        int   lat1;
        q_ee.push_back(model(a, b, un, f3, 1'b1));
        q_fu.push_back(model(a, b, un, f3, 1'b0));
        @(negedge clk);
        in_valid = 1'b1; rs1 = a; rs2 = b; br_un = un; funct3 = f3; in_ready = 1'b0;
        @(posedge clk); #1;
        // Scramble the inputs: the captured request must not depend on them.
        in_valid = 1'b0; rs1 = ~a; rs2 = ~b ^ 32'h0000_0F0F; br_un = ~un; funct3 = ~f3;
        check_bit({tag, "_busy_ready_ee"}, ee_ready, 1'b0);
        check_bit({tag, "_busy_ready_fu"}, fu_ready, 1'b0);
        lat = 0; lat0 = -1; lat1 = -1;
        while ((lat0 < 0 || lat1 < 0) && lat < 16) begin
            @(posedge clk); #1;
            lat++;
            if (lat0 < 0 && ee_valid) lat0 = lat;
            if (lat1 < 0 && fu_valid) lat1 = lat;
        end
        e0 = q_ee.pop_front();
        e1 = q_fu.pop_front();
        check_int({tag, "_lat_ee"}, lat0, e0.lat);
        check_int({tag, "_lat_fu"}, lat1, e1.lat);
        check_bit({tag, "_less_ee"}, ee_less, e0.less);
        check_bit({tag, "_equal_ee"}, ee_equal, e0.equal);
        check_bit({tag, "_taken_ee"}, ee_taken, e0.taken);
        check_bit({tag, "_illegal_ee"}, ee_illegal, e0.illegal);
        check_bit({tag, "_less_fu"}, fu_less, e1.less);
        check_bit({tag, "_equal_fu"}, fu_equal, e1.equal);
        check_bit({tag, "_taken_fu"}, fu_taken, e1.taken);
        check_bit({tag, "_illegal_fu"}, fu_illegal, e1.illegal);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid = 1'b1; rs1 = $urandom; rs2 = $urandom; funct3 = 3'b001;
            @(posedge clk); #1;
            check_bit({tag, "_hold_valid_ee"}, ee_valid, 1'b1);
            check_bit({tag, "_hold_valid_fu"}, fu_valid, 1'b1);
            check_bit({tag, "_hold_ready_ee"}, ee_ready, 1'b0);
            check_bit({tag, "_hold_less_ee"}, ee_less, e0.less);
            check_bit({tag, "_hold_equal_ee"}, ee_equal, e0.equal);
            check_bit({tag, "_hold_taken_ee"}, ee_taken, e0.taken);
            check_bit({tag, "_hold_taken_fu"}, fu_taken, e1.taken);
        end
        @(negedge clk);
        in_valid = 1'b0; in_ready = 1'b1;
        @(posedge clk); #1;
        check_bit({tag, "_post_valid_ee"}, ee_valid, 1'b0);
        check_bit({tag, "_post_valid_fu"}, fu_valid, 1'b0);
        check_bit({tag, "_post_ready_ee"}, ee_ready, 1'b1);
        check_bit({tag, "_post_ready_fu"}, fu_ready, 1'b1);
        @(negedge clk);
        in_ready = 1'b0;
    endtask

    logic [2:0] legal_f3 [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        stray;

        // Reset with a request pending: nothing must be captured.
        rst_n = 1'b0; in_valid = 1'b1; rs1 = 32'h1234_5678; rs2 = 32'h1234_5678;
        br_un = 1'b0; funct3 = 3'b000; in_ready = 1'b0;
        @(posedge clk); #1;
        check_bit("rst_ready_ee", ee_ready, 1'b1);
        check_bit("rst_ready_fu", fu_ready, 1'b1);
        check_bit("rst_valid_ee", ee_valid, 1'b0);
        check_bit("rst_less_ee", ee_less, 1'b0);
        check_bit("rst_equal_ee", ee_equal, 1'b0);
        check_bit("rst_taken_ee", ee_taken, 1'b0);
        check_bit("rst_illegal_ee", ee_illegal, 1'b0);
        @(posedge clk); #1;
        check_bit("rst2_valid_fu", fu_valid, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        check_bit("rst_nocap_ready_ee", ee_ready, 1'b1);
        check_bit("rst_nocap_valid_ee", ee_valid, 1'b0);

        // Directed cases.
        do_req("beq_eq",   32'h1234_5678, 32'h1234_5678, 1'b0, 3'b000, 0);
        do_req("blt_neg",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b100, 0);
        do_req("bltu_big", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b110, 0);
        do_req("blt_un",   32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b100, 0);
        do_req("bgeu_lo",  32'h0000_0010, 32'h0000_0020, 1'b0, 3'b111, 0);
        do_req("illegal",  32'h0000_0010, 32'h0000_0020, 1'b0, 3'b010, 0);
        do_req("ill_011",  32'h8000_0000, 32'h8000_0000, 1'b0, 3'b011, 0);
        do_req("bne_mid",  32'hAB00_0000, 32'hAB01_0000, 1'b0, 3'b001, 0);
        do_req("bge_top",  32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 3'b101, 0);
        do_req("blt_d1",   32'h8000_0000, 32'h8000_0100, 1'b0, 3'b100, 0);

        // Backpressure: result held for 3 cycles with a competing request.
        do_req("bp",       32'h0000_0005, 32'h0000_0009, 1'b0, 3'b100, 3);

        // Random mix, half of them differing in a single bit.
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            if (i % 2 == 1) b = a ^ (32'h1 << $urandom_range(31, 0));
            else            b = $urandom;
            do_req($sformatf("rnd%0d", i), a, b, 1'($urandom_range(1, 0)),
                   legal_f3[$urandom_range(5, 0)], 0);
        end

        // Reset while both instances are in CMP.
        @(negedge clk);
        in_valid = 1'b1; rs1 = 32'hCAFE_F00D; rs2 = 32'hCAFE_F00D; funct3 = 3'b000; br_un = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_bit("mid_rst_valid_ee", ee_valid, 1'b0);
        check_bit("mid_rst_ready_ee", ee_ready, 1'b1);
        check_bit("mid_rst_ready_fu", fu_ready, 1'b1);
        check_bit("mid_rst_taken_ee", ee_taken, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            stray = stray | ee_valid | fu_valid;
        end
        check_bit("mid_rst_no_result", stray, 1'b0);
        do_req("after_rst", 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 3'b000, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
